// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared defaults, feed length and state encoding for the skew feeder
package sa_pkg;

  localparam int SA_SIZE       = 4;
  localparam int SA_DATA_WIDTH = 10;
  localparam int FEED_CYCLES   = 2 * SA_SIZE + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_FEED  = 2'd2,
    ST_DRAIN = 2'd3
  } feeder_state_t;

  // Beats needed to push a full skewed wavefront through a size x size array
  function automatic int feed_cycles(input int size);
    return 2 * size + 1;
  endfunction

endpackage

// File: rtl/sa_skew_lane.sv
// rtl/sa_skew_lane.sv - per-lane skew select: row[beat-LANE] inside the window, else zero
module sa_skew_lane #(
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 10,
  parameter int LANE       = 0,
  parameter int TW         = 4
) (
  input  logic [TW-1:0]                beat,
  input  logic signed [DATA_WIDTH-1:0] row [SIZE],
  output logic signed [DATA_WIDTH-1:0] value
);

  always_comb begin
    value = '0;
    for (int k = 0; k < SIZE; k++) begin
      if (beat == TW'(k + LANE)) value = row[k];
    end
  end

endmodule

// File: rtl/sa_skew_feeder.sv
// rtl/sa_skew_feeder.sv - buffers one A/B job and streams it skewed into a systolic array
module sa_skew_feeder
  import sa_pkg::*;
#(
  parameter int SIZE       = SA_SIZE,
  parameter int DATA_WIDTH = SA_DATA_WIDTH,
  parameter int DRAIN_MAX  = 4 * SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] a_mat [SIZE][SIZE],
  input  logic signed [DATA_WIDTH-1:0] b_mat [SIZE][SIZE],
  output logic                         sa_clear,
  output logic signed [DATA_WIDTH-1:0] a_out [SIZE],
  output logic signed [DATA_WIDTH-1:0] b_out [SIZE],
  output logic                         out_valid,
  input  logic                         sa_done,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int FEED_N = feed_cycles(SIZE);
  localparam int TW     = $clog2(FEED_N + 1);
  localparam int DCW    = $clog2(DRAIN_MAX + 1);
  localparam logic [TW-1:0]  LAST_BEAT  = TW'(FEED_N - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MAX - 1);

  feeder_state_t state;
  logic [TW-1:0]  beat;
  logic [TW-1:0]  sel_beat;
  logic [DCW-1:0] drain_cnt;
  logic           load_beat;

  logic signed [DATA_WIDTH-1:0] buf_a [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0] buf_b [SIZE][SIZE];
  logic signed [DATA_WIDTH-1:0] lane_a [SIZE];
  logic signed [DATA_WIDTH-1:0] lane_b [SIZE];

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  // Output registers are loaded one cycle ahead, so lanes look at the next beat
  always_comb begin
    load_beat = (state == ST_CLEAR) || ((state == ST_FEED) && (beat != LAST_BEAT));
    sel_beat  = (state == ST_CLEAR) ? '0 : beat + TW'(1);
  end

  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    sa_skew_lane #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .LANE(g), .TW(TW)) u_lane_a (
      .beat  (sel_beat),
      .row   (buf_a[g]),
      .value (lane_a[g])
    );
    sa_skew_lane #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .LANE(g), .TW(TW)) u_lane_b (
      .beat  (sel_beat),
      .row   (buf_b[g]),
      .value (lane_b[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      beat        <= '0;
      drain_cnt   <= '0;
      sa_clear    <= 1'b0;
      out_valid   <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        a_out[i] <= '0;
        b_out[i] <= '0;
      end
    end else begin
      sa_clear    <= 1'b0;
      timeout_err <= 1'b0;
      out_valid   <= load_beat;
      for (int i = 0; i < SIZE; i++) begin
        a_out[i] <= load_beat ? lane_a[i] : '0;
        b_out[i] <= load_beat ? lane_b[i] : '0;
      end
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            buf_a    <= a_mat;
            buf_b    <= b_mat;
            sa_clear <= 1'b1;
            state    <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          beat  <= '0;
          state <= ST_FEED;
        end
        ST_FEED: begin
          if (beat == LAST_BEAT) begin
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end else begin
            beat <= beat + TW'(1);
          end
        end
        ST_DRAIN: begin
          if (sa_done) begin
            state <= ST_IDLE;
          end else if (drain_cnt == DRAIN_LAST) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sa_skew_feeder.md
SA_SKEW_FEEDER -- requirements
Module: sa_skew_feeder

Interface
REQ-001 SHALL have parameter SIZE, default 4, the array dimension (lanes per operand).
REQ-002 SHALL have parameter DATA_WIDTH, default 10, the signed operand width.
REQ-003 SHALL have parameter DRAIN_MAX, default 4*SIZE, the maximum cycles to wait for sa_done after feeding.
REQ-004 Port clk, input, 1: the single clock; one clock; reset is synchronous and active-high.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port in_valid, input, 1: a_mat/b_mat hold a new job.
REQ-007 Port in_ready, output, 1: feeder can accept a job.
REQ-008 Port a_mat, input, signed DATA_WIDTH x [SIZE][SIZE]: a_mat[i][k] = A row i, element k.
REQ-009 Port b_mat, input, signed DATA_WIDTH x [SIZE][SIZE]: b_mat[j][k] = operand stream for B lane j, element k.
REQ-010 Port sa_clear, output, 1: one-cycle clear pulse to the systolic array accumulators.
REQ-011 Port a_out, output, signed DATA_WIDTH x [SIZE]: skewed A lane values to the array.
REQ-012 Port b_out, output, signed DATA_WIDTH x [SIZE]: skewed B lane values to the array.
REQ-013 Port out_valid, output, 1: a_out/b_out carry a feed beat.
REQ-014 Port sa_done, input, 1: array reports that the result matrix is complete.
REQ-015 Port busy, output, 1: a job is in progress.
REQ-016 Port timeout_err, output, 1: one-cycle pulse when DRAIN exceeds DRAIN_MAX.

Function
REQ-017 Handshake: a job is accepted on a rising clk edge where in_valid && in_ready; a_mat/b_mat are copied into internal buffers on that edge.
REQ-018 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 in every other state.
REQ-019 States: IDLE, CLEAR, FEED, DRAIN. Transitions: IDLE->CLEAR on accept; CLEAR->FEED after 1 cycle; FEED->DRAIN after FEED_CYCLES = 2*SIZE+1 beats; DRAIN->IDLE on sa_done or timeout.
REQ-020 sa_clear SHALL be 1 exactly during the CLEAR cycle.
REQ-021 In FEED, beat counter t runs 0..2*SIZE; out_valid=1 for every beat.
REQ-022 For beat t: a_out[i] = buf_a[i][t-i] when 0 <= t-i < SIZE, else 0; b_out[j] = buf_b[j][t-j] under the same rule.
REQ-023 a_out, b_out, out_valid and sa_clear SHALL be registered; outside FEED, a_out and b_out SHALL be 0 and out_valid 0.
REQ-024 Latency: when a job is accepted at edge N, sa_clear is high in cycle N+1 and beat 0 appears in cycle N+2; beat 2*SIZE appears in cycle N+2*SIZE+2.
REQ-025 sa_done SHALL be ignored outside DRAIN; sa_done in the first DRAIN cycle SHALL return the block to IDLE on the next edge.
REQ-026 DRAIN cycle counter: if DRAIN_MAX cycles elapse without sa_done, go to IDLE and pulse timeout_err for 1 cycle.
REQ-027 Operand values pass through unmodified; no arithmetic is performed; buffers are stable for the whole job.
REQ-028 in_valid while busy SHALL have no effect; the job is held off by in_ready=0.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, clear all counters, and drive in_ready=1 (after reset), busy=0, out_valid=0, sa_clear=0, timeout_err=0, and a_out=b_out=0.
REQ-030 Reset mid-FEED or mid-DRAIN SHALL abort the job without a timeout_err pulse; buffer contents are don't-care.

Structure
REQ-031 Package sa_pkg SHALL hold the SIZE/DATA_WIDTH defaults, the FEED_CYCLES localparam, and the feeder state enum.
REQ-032 One sub-module, sa_skew_lane, SHALL implement the per-lane index-and-zero select of REQ-022; it is instantiated 2*SIZE times.

Verification
REQ-033 SIZE=4. Load A rows [1 2 3 4],[9 10 11 12],[13 14 15 16],[17 18 19 20] and b_mat rows [5 6 7 8],[9..12],[13..16],[17..20] -> beat 0: a_out={1,0,0,0}, b_out={5,0,0,0}; beat 3: a_out={4,11,14,17}; beat 6: a_out={0,0,0,20}; beats 7 and 8 all zero.
REQ-034 Accept at edge N -> sa_clear high only in cycle N+1; out_valid high exactly in cycles N+2..N+10; in_ready low from N+1 until return to IDLE.
REQ-035 sa_done pulsed during FEED beat 4, then again in DRAIN cycle 2 -> first pulse ignored; IDLE reached after the second; timeout_err stays 0.
REQ-036 sa_done never asserted -> timeout_err pulses once, 16 cycles after DRAIN entry, then IDLE with in_ready=1.
REQ-037 rst asserted at FEED beat 3 -> next cycle all outputs at reset values; a new job then replays from beat 0 with correct data.
REQ-038 in_valid held high continuously over two jobs -> second job is accepted only on the first IDLE cycle; no beat is lost or duplicated.
